gpreg_wb_sched: RTL and testbench

- Sequencer and write-port arbiter for the 8x32 general-purpose register file.
- Two write-back requesters share the single register-file write port: ALU result and memory load.
- A scoreboard of pending destination registers stalls the issue stage on RAW/WAW hazards.
- Drives the register file's SelX/SelY/SelZ/MemInstruction/MemData inputs, and produces a valid strobe aligned with the file's registered A/B outputs.

---
 rtl/gpreg_wb_sched.sv | 208 ++++++++++++++++++++
 tb/tb_gpreg_wb_sched.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpreg_wb_sched.sv
// -----------------------------------------------------------------------------
// gpreg_wb_sched
//
// Purpose:
//   Sequencer and write-port arbiter for the 8x32 general-purpose register
//   file. Two write-back sources (ALU result and memory load) share the single
//   register-file write port. A scoreboard of outstanding destination
//   registers stalls the issue stage on RAW/WAW hazards. The block drives the
//   register file's SelX/SelY/SelZ/MemInstruction/MemData inputs and produces
//   a valid strobe aligned with the file's registered A/B outputs.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   iss_valid       issue request
//   iss_ready       issue accepted this cycle (combinational)
//   iss_srcx/srcy   operand X / Y register numbers
//   iss_dst_en      issued instruction will write a register
//   iss_dst         destination register of the issued instruction
//   alu_req/dst/data  ALU write-back request, destination, result
//   alu_gnt         ALU write accepted (combinational)
//   mem_req/dst/data  load write-back request, destination, data
//   mem_gnt         load write accepted (combinational)
//   rf_selx/sely    register-file read selects (registered)
//   rf_selz         register-file write select (registered)
//   rf_meminstr     register-file MemInstruction, 11 = write, 00 = NOP
//   rf_memdata      register-file MemData (registered)
//   rd_valid        register-file A/B hold operands of an accepted issue
//   pending         scoreboard, bit n = write to Rn outstanding
//   err_spurious    sticky flag: write-back granted to a non-pending register
// -----------------------------------------------------------------------------
module gpreg_wb_sched #(
   parameter int NREG = 8,
   parameter int DW   = 32
) (
   input  logic            clk,
   input  logic            rst,

   input  logic            iss_valid,
   output logic            iss_ready,
   input  logic [2:0]      iss_srcx,
   input  logic [2:0]      iss_srcy,
   input  logic            iss_dst_en,
   input  logic [2:0]      iss_dst,

   input  logic            alu_req,
   input  logic [2:0]      alu_dst,
   input  logic [DW-1:0]   alu_data,
   output logic            alu_gnt,

   input  logic            mem_req,
   input  logic [2:0]      mem_dst,
   input  logic [DW-1:0]   mem_data,
   output logic            mem_gnt,

   output logic [2:0]      rf_selx,
   output logic [2:0]      rf_sely,
   output logic [2:0]      rf_selz,
   output logic [1:0]      rf_meminstr,
   output logic [DW-1:0]   rf_memdata,
   output logic            rd_valid,
   output logic [NREG-1:0] pending,
   output logic            err_spurious
);

   // Round-robin arbiter state: which requester wins the next conflict.
   typedef enum logic {
      ARB_ALU_FIRST = 1'b0,
      ARB_MEM_FIRST = 1'b1
   } arb_state_t;

   arb_state_t      arb_state;
   arb_state_t      arb_next;

   logic            hz;
   logic            accept;
   logic            valid_s1;
   logic            wb_any;
   logic            wb_spurious;
   logic [2:0]      wb_dst;
   logic [DW-1:0]   wb_data;
   logic [NREG-1:0] set_mask;
   logic [NREG-1:0] clr_mask;
   logic [NREG-1:0] pending_next;

   // Hazard detection looks only at the registered scoreboard. A write-back
   // clearing a bit in this same cycle does not unblock the issue; the stall
   // simply lasts one cycle longer, which keeps the issue path short.
   always_comb begin
      hz = pending[iss_srcx] | pending[iss_srcy] | (iss_dst_en & pending[iss_dst]);
      accept = iss_valid & ~hz;
   end

   assign iss_ready = accept;

   // Arbiter state register. After reset the ALU wins the first conflict.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         arb_state <= ARB_ALU_FIRST;
      end else begin
         arb_state <= arb_next;
      end
   end

   // Arbiter next state. The pointer moves only when both requesters competed,
   // so a lone request never disturbs the fairness order.
   always_comb begin
      arb_next = arb_state;
      if (alu_req && mem_req) begin
         if (arb_state == ARB_ALU_FIRST) begin
            arb_next = ARB_MEM_FIRST;
         end else begin
            arb_next = ARB_ALU_FIRST;
         end
      end
   end

   // Arbiter outputs. A lone request is always granted; on a conflict the
   // requester named by the state wins.
   always_comb begin
      alu_gnt = 1'b0;
      mem_gnt = 1'b0;
      if (arb_state == ARB_ALU_FIRST) begin
         alu_gnt = alu_req;
         mem_gnt = mem_req & ~alu_req;
      end else begin
         mem_gnt = mem_req;
         alu_gnt = alu_req & ~mem_req;
      end
   end

   // Select the winning write-back onto the single register-file write port.
   always_comb begin
      wb_any  = alu_gnt | mem_gnt;
      wb_dst  = mem_dst;
      wb_data = mem_data;
      if (alu_gnt) begin
         wb_dst  = alu_dst;
         wb_data = alu_data;
      end
      wb_spurious = wb_any & ~pending[wb_dst];
   end

   // Scoreboard update masks. Set is applied after clear, so a new issue that
   // targets the register being written back keeps ownership of that bit.
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (accept && iss_dst_en) begin
         set_mask[iss_dst] = 1'b1;
      end
      if (wb_any) begin
         clr_mask[wb_dst] = 1'b1;
      end
      pending_next = (pending & ~clr_mask) | set_mask;
   end

   // Scoreboard and sticky error flag. The error flag is cleared only by reset
   // so that software can find a protocol violation long after it happened.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending      <= '0;
         err_spurious <= 1'b0;
      end else begin
         pending <= pending_next;
         if (wb_spurious) begin
            err_spurious <= 1'b1;
         end
      end
   end

   // Issue pipe. The read selects are registered here, the register file
   // registers A/B one edge later, so the valid strobe runs through two
   // stages to line up with the operands leaving the file.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_selx  <= 3'd0;
         rf_sely  <= 3'd0;
         valid_s1 <= 1'b0;
         rd_valid <= 1'b0;
      end else begin
         if (accept) begin
            rf_selx <= iss_srcx;
            rf_sely <= iss_srcy;
         end
         valid_s1 <= accept;
         rd_valid <= valid_s1;
      end
   end

   // Write port. A grant turns into a one-cycle write command; without a
   // grant the command drops to NOP while select and data hold their values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_selz     <= 3'd0;
         rf_meminstr <= 2'b00;
         rf_memdata  <= '0;
      end else begin
         if (wb_any) begin
            rf_selz     <= wb_dst;
            rf_memdata  <= wb_data;
            rf_meminstr <= 2'b11;
         end else begin
            rf_meminstr <= 2'b00;
         end
      end
   end

endmodule

// File: tb/tb_gpreg_wb_sched.sv
// -----------------------------------------------------------------------------
// tb_gpreg_wb_sched
//
// Purpose:
//   Directed self-checking bench for gpreg_wb_sched. The stimulus process
//   drives hand-written vectors and pushes the write-port commands and
//   operand-valid strobes it expects into queues; a monitor process pops and
//   compares whenever the DUT presents a write or an rd_valid pulse.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_gpreg_wb_sched;

   localparam int DW = 32;

   logic          clk;
   logic          rst;
   logic          iss_valid;
   logic          iss_ready;
   logic [2:0]    iss_srcx;
   logic [2:0]    iss_srcy;
   logic          iss_dst_en;
   logic [2:0]    iss_dst;
   logic          alu_req;
   logic [2:0]    alu_dst;
   logic [DW-1:0] alu_data;
   logic          alu_gnt;
   logic          mem_req;
   logic [2:0]    mem_dst;
   logic [DW-1:0] mem_data;
   logic          mem_gnt;
   logic [2:0]    rf_selx;
   logic [2:0]    rf_sely;
   logic [2:0]    rf_selz;
   logic [1:0]    rf_meminstr;
   logic [DW-1:0] rf_memdata;
   logic          rd_valid;
   logic [7:0]    pending;
   logic          err_spurious;

   typedef struct {
      logic [2:0]  dst;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   wr_t  wr_q[$];
   int   rd_q[$];
   wr_t  mon_wr;
   int   mon_rd;
   int   cyc = 0;
   int   compared = 0;
   int   mismatched = 0;

   gpreg_wb_sched #(.NREG(8), .DW(DW)) dut (
      .clk          (clk),
      .rst          (rst),
      .iss_valid    (iss_valid),
      .iss_ready    (iss_ready),
      .iss_srcx     (iss_srcx),
      .iss_srcy     (iss_srcy),
      .iss_dst_en   (iss_dst_en),
      .iss_dst      (iss_dst),
      .alu_req      (alu_req),
      .alu_dst      (alu_dst),
      .alu_data     (alu_data),
      .alu_gnt      (alu_gnt),
      .mem_req      (mem_req),
      .mem_dst      (mem_dst),
      .mem_data     (mem_data),
      .mem_gnt      (mem_gnt),
      .rf_selx      (rf_selx),
      .rf_sely      (rf_sely),
      .rf_selz      (rf_selz),
      .rf_meminstr  (rf_meminstr),
      .rf_memdata   (rf_memdata),
      .rd_valid     (rd_valid),
      .pending      (pending),
      .err_spurious (err_spurious)
   );

   // Free-running clock and a cycle counter used to time-stamp expectations.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // One comparison: count it, report it when it does not match.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Drive one cycle of inputs shortly after the rising edge, then let the
   // combinational outputs settle before the caller checks them.
   task automatic applyStimulus(input logic iv, input logic [2:0] sx, input logic [2:0] sy,
                                input logic de, input logic [2:0] d,
                                input logic ar, input logic [2:0] ad, input logic [31:0] adat,
                                input logic mr, input logic [2:0] md, input logic [31:0] mdat);
      @(posedge clk);
      #1;
      iss_valid  = iv;
      iss_srcx   = sx;
      iss_srcy   = sy;
      iss_dst_en = de;
      iss_dst    = d;
      alu_req    = ar;
      alu_dst    = ad;
      alu_data   = adat;
      mem_req    = mr;
      mem_dst    = md;
      mem_data   = mdat;
      #1;
   endtask

   task automatic idle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic zeroInputs();
      iss_valid  = 0;
      iss_srcx   = 0;
      iss_srcy   = 0;
      iss_dst_en = 0;
      iss_dst    = 0;
      alu_req    = 0;
      alu_dst    = 0;
      alu_data   = 0;
      mem_req    = 0;
      mem_dst    = 0;
      mem_data   = 0;
   endtask

   // Expectations relative to the cycle in which the inputs were just driven.
   task automatic expectRead();
      rd_q.push_back(cyc + 2);
   endtask

   task automatic expectWrite(input logic [2:0] d, input logic [31:0] data);
      wr_t w;
      w.dst  = d;
      w.data = data;
      w.cyc  = cyc + 1;
      wr_q.push_back(w);
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_selx"}, 32'(rf_selx), 0);
      checkOutput({tag, "_sely"}, 32'(rf_sely), 0);
      checkOutput({tag, "_selz"}, 32'(rf_selz), 0);
      checkOutput({tag, "_meminstr"}, 32'(rf_meminstr), 0);
      checkOutput({tag, "_memdata"}, rf_memdata, 0);
      checkOutput({tag, "_rd_valid"}, 32'(rd_valid), 0);
      checkOutput({tag, "_pending"}, 32'(pending), 0);
      checkOutput({tag, "_err"}, 32'(err_spurious), 0);
   endtask

   task automatic doReset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      zeroInputs();
      #2;
      rst = 1'b0;
   endtask

   // Monitor: every write command and every rd_valid pulse must match the
   // oldest outstanding expectation, including the cycle it was due in.
   always @(negedge clk) begin
      if (!rst) begin
         if (rd_valid) begin
            if (rd_q.size() == 0) begin
               compared++;
               mismatched++;
               $display("[TB] FAIL rd_valid_unexpected: got 1, expected 0 (cycle %0d)", cyc);
            end else begin
               mon_rd = rd_q.pop_front();
               checkOutput("rd_valid_cycle", cyc, mon_rd);
            end
         end
         if (rf_meminstr != 2'b00) begin
            if (wr_q.size() == 0) begin
               compared++;
               mismatched++;
               $display("[TB] FAIL write_unexpected: got meminstr %b selz %0d, expected NOP (cycle %0d)",
                        rf_meminstr, rf_selz, cyc);
            end else begin
               mon_wr = wr_q.pop_front();
               checkOutput("wr_meminstr", 32'(rf_meminstr), 3);
               checkOutput("wr_selz", 32'(rf_selz), 32'(mon_wr.dst));
               checkOutput("wr_memdata", rf_memdata, mon_wr.data);
               checkOutput("wr_cycle", cyc, mon_wr.cyc);
            end
         end
      end
   end

   logic [5:0] alu_first_pat;
   int         ai;
   int         mi;

   initial begin
      rst = 1'b1;
      zeroInputs();
      #3;
      checkResetState("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Plain issue, no destination: selects follow, rd_valid two cycles later.
      applyStimulus(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("a_iss_ready", 32'(iss_ready), 1);
      expectRead();
      idle();
      checkOutput("a_selx", 32'(rf_selx), 1);
      checkOutput("a_sely", 32'(rf_sely), 2);
      checkOutput("a_rd_valid_early", 32'(rd_valid), 0);

      // Issue with dst=3, then a RAW stall on R3 until the ALU writes it.
      applyStimulus(1, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0);
      checkOutput("a_dst3_ready", 32'(iss_ready), 1);
      expectRead();
      applyStimulus(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("a_pending_r3", 32'(pending), 32'h08);
      checkOutput("a_raw_stall1", 32'(iss_ready), 0);
      applyStimulus(1, 3, 0, 0, 0, 1, 3, 32'hDEADBEEF, 0, 0, 0);
      checkOutput("a_raw_stall2", 32'(iss_ready), 0);
      checkOutput("a_alu_gnt", 32'(alu_gnt), 1);
      checkOutput("a_mem_gnt", 32'(mem_gnt), 0);
      expectWrite(3, 32'hDEADBEEF);
      applyStimulus(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("a_pending_clear", 32'(pending), 0);
      checkOutput("a_raw_release", 32'(iss_ready), 1);
      checkOutput("a_selz", 32'(rf_selz), 3);
      checkOutput("a_meminstr", 32'(rf_meminstr), 3);
      checkOutput("a_memdata", rf_memdata, 32'hDEADBEEF);
      checkOutput("a_err", 32'(err_spurious), 0);
      expectRead();
      idle();
      idle();
      idle();

      // Conflict straight out of reset: ALU first, then the held MEM request.
      doReset();
      applyStimulus(0, 0, 0, 0, 0, 1, 4, 32'h44, 1, 5, 32'h55);
      checkOutput("b_alu_gnt1", 32'(alu_gnt), 1);
      checkOutput("b_mem_gnt1", 32'(mem_gnt), 0);
      expectWrite(4, 32'h44);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 32'h55);
      checkOutput("b_alu_gnt2", 32'(alu_gnt), 0);
      checkOutput("b_mem_gnt2", 32'(mem_gnt), 1);
      expectWrite(5, 32'h55);
      idle();
      checkOutput("b_err_spurious", 32'(err_spurious), 1);
      checkOutput("b_pending", 32'(pending), 0);
      idle();
      idle();

      // Six cycles of continuous competition must alternate ALU, MEM, ...
      doReset();
      alu_first_pat = 6'b010101;
      ai = 0;
      mi = 0;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(0, 0, 0, 0, 0, 1, 3'(ai + 1), 32'hA000_0000 + ai,
                       1, 3'(mi + 4), 32'hB000_0000 + mi);
         checkOutput($sformatf("c_alu_gnt%0d", i), 32'(alu_gnt), 32'(alu_first_pat[i]));
         checkOutput($sformatf("c_mem_gnt%0d", i), 32'(mem_gnt), 32'(!alu_first_pat[i]));
         if (alu_first_pat[i]) begin
            expectWrite(3'(ai + 1), 32'hA000_0000 + ai);
            ai++;
         end else begin
            expectWrite(3'(mi + 4), 32'hB000_0000 + mi);
            mi++;
         end
      end
      idle();
      idle();
      idle();

      // WAW on R6: reissue stalls until the write-back clears the bit.
      doReset();
      applyStimulus(1, 0, 0, 1, 6, 0, 0, 0, 0, 0, 0);
      checkOutput("d_iss6_ready", 32'(iss_ready), 1);
      expectRead();
      idle();
      applyStimulus(1, 0, 0, 1, 6, 1, 6, 32'h66, 0, 0, 0);
      checkOutput("d_pending_r6", 32'(pending), 32'h40);
      checkOutput("d_waw_stall", 32'(iss_ready), 0);
      checkOutput("d_alu_gnt", 32'(alu_gnt), 1);
      expectWrite(6, 32'h66);
      applyStimulus(1, 0, 0, 1, 6, 0, 0, 0, 0, 0, 0);
      checkOutput("d_pending_clr", 32'(pending), 0);
      checkOutput("d_err_clean", 32'(err_spurious), 0);
      checkOutput("d_reissue_ready", 32'(iss_ready), 1);
      expectRead();

      // Issue dst=7 while a write-back to the non-pending R7 is granted:
      // the set wins and the spurious flag latches.
      applyStimulus(1, 0, 0, 1, 7, 0, 0, 0, 1, 7, 32'h77);
      checkOutput("d_pending_r6_again", 32'(pending), 32'h40);
      checkOutput("d_iss7_ready", 32'(iss_ready), 1);
      checkOutput("d_mem_gnt", 32'(mem_gnt), 1);
      expectRead();
      expectWrite(7, 32'h77);
      idle();
      checkOutput("d_set_wins", 32'(pending), 32'hC0);
      checkOutput("d_err_set", 32'(err_spurious), 1);
      idle();
      checkOutput("d_err_sticky", 32'(err_spurious), 1);

      // Reset in the middle of an accepted issue and a granted write.
      applyStimulus(1, 2, 3, 1, 1, 1, 6, 32'h99, 0, 0, 0);
      checkOutput("e_iss_ready", 32'(iss_ready), 1);
      checkOutput("e_alu_gnt", 32'(alu_gnt), 1);
      #2;
      rst = 1'b1;
      zeroInputs();
      #1;
      checkResetState("midreset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle();
      checkOutput("e_no_write", 32'(rf_meminstr), 0);
      checkOutput("e_pending", 32'(pending), 0);
      checkOutput("e_rd_valid", 32'(rd_valid), 0);
      idle();
      idle();
      idle();

      checkOutput("drain_rd_queue", rd_q.size(), 0);
      checkOutput("drain_wr_queue", wr_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
